// File: rtl/jpeg_blk_seq.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_blk_seq
// Description : Walks a raster RGB image as 8x8 blocks and streams each pixel
//               word from a req/gnt memory port into the JPEG encoder port.
// Revision    : 1.0 - initial release
// ============================================================================
module jpeg_blk_seq #(
    parameter int AW = 32,
    parameter int BW = 10,
    parameter int FD = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [AW-1:0] base_i,
    input  logic [AW-1:0] stride_i,
    input  logic [BW-1:0] blk_x_i,
    input  logic [BW-1:0] blk_y_i,
    output logic          mem_req_o,
    output logic [AW-1:0] mem_addr_o,
    input  logic          mem_gnt_i,
    input  logic          mem_rvalid_i,
    input  logic [31:0]   mem_rdata_i,
    output logic          enc_req_o,
    output logic [31:0]   enc_wdata_o,
    output logic          enc_last_o,
    input  logic          enc_gnt_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [BW-1:0] cur_bx_o,
    output logic [BW-1:0] cur_by_o
);

    localparam int c_PW = $clog2(FD);
    localparam int c_CW = c_PW + 1;
    localparam int c_SW = c_CW + 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]    r_state, w_next;
    logic [AW-1:0] r_stride, r_addr, r_row_start, r_blk_start, r_brow_start;
    logic [BW-1:0] r_bx_max, r_by_max, r_bx, r_by;
    logic [2:0]    r_col, r_row;
    logic [c_CW-1:0] r_outst, r_pend_nl, r_cnt;
    logic [c_PW-1:0] r_wr, r_rd;
    logic [31:0]   r_data  [FD];
    logic          r_lflag [FD];

    logic          w_room, w_fire, w_push, w_pop, w_nempty;
    logic          w_fetch_last, w_final_pix;
    logic [BW-1:0] w_bx_last, w_by_last;
    logic [AW-1:0] w_next_row, w_next_blk, w_next_brow;

    assign w_bx_last    = r_bx_max - BW'(1);
    assign w_by_last    = r_by_max - BW'(1);
    assign w_fetch_last = (r_bx == w_bx_last) && (r_by == w_by_last);
    assign w_final_pix  = w_fetch_last && (r_row == 3'd7) && (r_col == 3'd7);
    // Reads in flight plus buffered words never exceed the FIFO depth
    assign w_room       = (c_SW'(r_outst) + c_SW'(r_cnt)) < c_SW'(FD);
    assign w_fire       = (r_state == c_FETCH) && w_room && mem_gnt_i;
    assign w_push       = mem_rvalid_i && (r_state != c_IDLE);
    assign w_nempty     = (r_cnt != '0);
    assign w_pop        = w_nempty && enc_gnt_i;
    assign w_next_row   = r_row_start + r_stride;
    assign w_next_blk   = r_blk_start + AW'(32);
    assign w_next_brow  = r_brow_start + {r_stride[AW-4:0], 3'b000};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= c_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (start_i)
                    w_next = ((blk_x_i == '0) || (blk_y_i == '0)) ? c_DONE : c_FETCH;
            end
            c_FETCH: if (w_fire && w_final_pix) w_next = c_DRAIN;
            c_DRAIN: if ((r_outst == '0) && (r_cnt == c_CW'(1)) && w_pop) w_next = c_DONE;
            default: w_next = c_IDLE;
        endcase
    end

    always_comb begin
        busy_o      = (r_state != c_IDLE);
        done_o      = (r_state == c_DONE);
        mem_req_o   = (r_state == c_FETCH) && w_room;
        enc_req_o   = w_nempty;
        enc_wdata_o = w_nempty ? r_data[r_rd] : 32'd0;
        enc_last_o  = w_nempty && r_lflag[r_rd];
    end

    assign mem_addr_o = r_addr;
    assign cur_bx_o   = r_bx;
    assign cur_by_o   = r_by;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stride     <= '0;
            r_addr       <= '0;
            r_row_start  <= '0;
            r_blk_start  <= '0;
            r_brow_start <= '0;
            r_bx_max     <= '0;
            r_by_max     <= '0;
            r_bx         <= '0;
            r_by         <= '0;
            r_col        <= '0;
            r_row        <= '0;
        end else if ((r_state == c_IDLE) && start_i) begin
            r_stride     <= stride_i;
            r_addr       <= base_i;
            r_row_start  <= base_i;
            r_blk_start  <= base_i;
            r_brow_start <= base_i;
            r_bx_max     <= blk_x_i;
            r_by_max     <= blk_y_i;
            r_bx         <= '0;
            r_by         <= '0;
            r_col        <= '0;
            r_row        <= '0;
        end else if (w_fire) begin
            if (r_col != 3'd7) begin
                r_col  <= r_col + 3'd1;
                r_addr <= r_addr + AW'(4);
            end else begin
                r_col <= '0;
                if (r_row != 3'd7) begin
                    r_row       <= r_row + 3'd1;
                    r_row_start <= w_next_row;
                    r_addr      <= w_next_row;
                end else begin
                    r_row <= '0;
                    if (r_bx != w_bx_last) begin
                        r_bx        <= r_bx + BW'(1);
                        r_blk_start <= w_next_blk;
                        r_row_start <= w_next_blk;
                        r_addr      <= w_next_blk;
                    end else begin
                        r_bx         <= '0;
                        r_by         <= r_by + BW'(1);
                        r_brow_start <= w_next_brow;
                        r_blk_start  <= w_next_brow;
                        r_row_start  <= w_next_brow;
                        r_addr       <= w_next_brow;
                    end
                end
            end
        end
    end

    // Non-final-block reads always precede final-block reads, so a counter of
    // outstanding non-final reads tags each returning word
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_outst   <= '0;
            r_pend_nl <= '0;
            r_cnt     <= '0;
            r_wr      <= '0;
            r_rd      <= '0;
        end else begin
            r_outst   <= r_outst + c_CW'(w_fire) - c_CW'(w_push);
            r_pend_nl <= r_pend_nl + c_CW'(w_fire && !w_fetch_last)
                                   - c_CW'(w_push && (r_pend_nl != '0));
            r_cnt     <= r_cnt + c_CW'(w_push) - c_CW'(w_pop);
            if (w_push) r_wr <= r_wr + c_PW'(1);
            if (w_pop)  r_rd <= r_rd + c_PW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_data[r_wr]  <= mem_rdata_i;
            r_lflag[r_wr] <= (r_pend_nl == '0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jpeg_blk_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_jpeg_blk_seq
// Description : Randomized self-checking bench for jpeg_blk_seq with a memory
//               responder, encoder sink and address/pixel reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jpeg_blk_seq;

    localparam int AW = 32;
    localparam int BW = 10;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic [AW-1:0] base_i = '0, stride_i = '0;
    logic [BW-1:0] blk_x_i = '0, blk_y_i = '0;
    logic          mem_req_o, mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_rdata_i = '0;
    logic          enc_req_o, enc_last_o, enc_gnt_i = 1'b0;
    logic [31:0]   enc_wdata_o;
    logic          busy_o, done_o;
    logic [BW-1:0] cur_bx_o, cur_by_o;

    always #5 clk = ~clk;

    jpeg_blk_seq #(.AW(AW), .BW(BW), .FD(FD)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_i),
        .base_i(base_i), .stride_i(stride_i), .blk_x_i(blk_x_i), .blk_y_i(blk_y_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .enc_req_o(enc_req_o), .enc_wdata_o(enc_wdata_o), .enc_last_o(enc_last_o),
        .enc_gnt_i(enc_gnt_i), .busy_o(busy_o), .done_o(done_o),
        .cur_bx_o(cur_bx_o), .cur_by_o(cur_by_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory contents: a fixed scramble of the byte address
    function automatic logic [31:0] pix(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    logic [31:0] exp_addr[$];
    int          gx;

    task automatic build(input logic [31:0] base, input logic [31:0] stride,
                         input int bx, input int by);
        exp_addr.delete();
        gx = bx;
        for (int y = 0; y < by; y++)
            for (int x = 0; x < bx; x++)
                for (int r = 0; r < 8; r++)
                    for (int c = 0; c < 8; c++)
                        exp_addr.push_back(base + 32'(y * 8 + r) * stride
                                           + 32'(x * 32) + 32'(c * 4));
    endtask

    typedef struct { logic [31:0] d; int due; } rsp_t;
    rsp_t pend[$];

    int cyc = 0, rd_idx = 0, wr_idx = 0, lat_max = 1, stall_cnt = 0, stalled_blk = -1;
    int last_pop_cyc = 0, done_cyc = 0, done_cnt = 0, mreq_cycles = 0, ereq_cycles = 0;
    bit gnt_rand = 0, enc_stall = 0;
    bit prev_mwait = 0, prev_ewait = 0;
    logic [31:0] prev_maddr = '0, prev_wd = '0;
    logic        prev_wl = 1'b0;

    // Inputs for the next rising edge are decided here from settled outputs
    always @(negedge clk) begin
        int due;
        cyc++;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = pend[0].d;
            void'(pend.pop_front());
        end else begin
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = $urandom;
        end
        if (!rst_n) begin
            prev_mwait = 0;
            prev_ewait = 0;
            mem_gnt_i  = 1'b0;
            enc_gnt_i  = 1'b0;
        end else begin
            if (done_o) begin done_cnt++; done_cyc = cyc; end
            if (mem_req_o) mreq_cycles++;
            if (prev_mwait) begin
                check("mreq_hold", mem_req_o, 1);
                check("maddr_hold", mem_addr_o, prev_maddr);
            end
            mem_gnt_i = gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (mem_req_o && mem_gnt_i) begin
                if (rd_idx < exp_addr.size()) begin
                    check("rd_addr", mem_addr_o, exp_addr[rd_idx]);
                    check("cur_bx", cur_bx_o, (rd_idx / 64) % gx);
                    check("cur_by", cur_by_o, (rd_idx / 64) / gx);
                end else
                    check("rd_extra", rd_idx, exp_addr.size());
                rd_idx++;
                check("fifo_budget", (rd_idx - wr_idx) <= FD, 1);
                due = cyc + $urandom_range(1, lat_max);
                if (pend.size() > 0 && pend[$].due >= due) due = pend[$].due + 1;
                pend.push_back('{pix(mem_addr_o), due});
            end
            prev_mwait = mem_req_o && !mem_gnt_i;
            prev_maddr = mem_addr_o;

            if (enc_req_o) ereq_cycles++;
            if (prev_ewait) begin
                check("ereq_hold", enc_req_o, 1);
                check("wdata_hold", enc_wdata_o, prev_wd);
                check("wlast_hold", enc_last_o, prev_wl);
            end
            if (enc_stall && enc_req_o && wr_idx % 64 == 0 && stalled_blk != wr_idx) begin
                stalled_blk = wr_idx;
                if (stall_cnt == 0) stall_cnt = $urandom_range(1, 8);
            end
            if (stall_cnt > 0) begin
                enc_gnt_i = 1'b0;
                stall_cnt--;
            end else
                enc_gnt_i = enc_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (enc_req_o && enc_gnt_i) begin
                if (wr_idx < exp_addr.size()) begin
                    check("wdata", enc_wdata_o, pix(exp_addr[wr_idx]));
                    check("wlast", enc_last_o, wr_idx >= exp_addr.size() - 64);
                end else
                    check("wr_extra", wr_idx, exp_addr.size());
                wr_idx++;
                last_pop_cyc = cyc;
                if (enc_stall && wr_idx % 64 == 0) stall_cnt = 32;
            end
            prev_ewait = enc_req_o && !enc_gnt_i;
            prev_wd    = enc_wdata_o;
            prev_wl    = enc_last_o;
        end
    end

    task automatic kick(input logic [31:0] base, input logic [31:0] stride,
                        input int bx, input int by, input int lat, input bit rnd);
        build(base, stride, bx, by);
        rd_idx = 0; wr_idx = 0; mreq_cycles = 0; ereq_cycles = 0; done_cnt = 0;
        stalled_blk = -1; stall_cnt = 0; lat_max = lat; gnt_rand = rnd; enc_stall = rnd;
        @(negedge clk);
        base_i = base; stride_i = stride; blk_x_i = BW'(bx); blk_y_i = BW'(by);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        // Geometry inputs must be ignored once latched
        base_i = $urandom; stride_i = $urandom; blk_x_i = BW'($urandom_range(1, 5));
    endtask

    task automatic run(input logic [31:0] base, input logic [31:0] stride,
                       input int bx, input int by, input int lat, input bit rnd,
                       input bit inject);
        int  n;
        bit  injected;
        kick(base, stride, bx, by, lat, rnd);
        n = 0;
        injected = 0;
        while (!done_o && n < exp_addr.size() * 20 + 200) begin
            @(negedge clk);
            n++;
            if (inject && !injected && rd_idx >= 20) begin
                blk_x_i = 3; blk_y_i = 3; base_i = 32'h0F00_0000;
                start_i = 1'b1;
                injected = 1;
            end else
                start_i = 1'b0;
        end
        start_i = 1'b0;
        if (!done_o) begin
            check("done_timeout", 0, 1);
            return;
        end
        if (exp_addr.size() == 0) check("zero_done_lat", n, 0);
        @(negedge clk);
        check("done_pulse", done_o, 0);
        check("busy_after", busy_o, 0);
        check("done_count", done_cnt, 1);
        check("rd_total", rd_idx, exp_addr.size());
        check("wr_total", wr_idx, exp_addr.size());
        if (exp_addr.size() == 0) begin
            check("zero_mreq", mreq_cycles, 0);
            check("zero_ereq", ereq_cycles, 0);
        end else
            check("done_after_gnt", done_cyc, last_pop_cyc + 1);
    endtask

    task automatic check_outs_zero(input string tag);
        check(tag, {busy_o, done_o, mem_req_o, enc_req_o, enc_last_o,
                    mem_addr_o, enc_wdata_o[19:0], cur_bx_o, cur_by_o}, 0);
    endtask

    initial begin
        int n;
        logic [31:0] b, s;
        int bx, by;
        repeat (3) @(negedge clk);
        check_outs_zero("reset_outs");
        check("reset_wdata", enc_wdata_o, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run(32'h1000, 32'h20, 1, 1, 1, 0, 0);
        run(32'h0, 32'h40, 2, 2, 1, 0, 0);
        run(32'h0, 32'h40, 2, 2, 6, 1, 0);
        run(32'h2000, 32'h100, 0, 5, 1, 0, 0);
        run(32'h4000, 32'h80, 2, 2, 3, 1, 1);

        // Abort during block 3 of a 4x1 transfer
        kick(32'h8000, 32'h100, 4, 1, 4, 1);
        n = 0;
        while (rd_idx < 150 && n < 5000) begin @(negedge clk); n++; end
        check("reach_blk3", rd_idx >= 150, 1);
        #2 rst_n = 1'b0;
        #1 check_outs_zero("async_reset_outs");
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (pend.size() > 0 && n < 100) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        check("idle_after_abort", {busy_o, mem_req_o, enc_req_o}, 0);
        run(32'h8000, 32'h100, 4, 1, 4, 1, 0);

        for (int t = 0; t < 4; t++) begin
            bx = $urandom_range(1, 3);
            by = $urandom_range(1, 2);
            b  = (t == 3) ? 32'hFFFF_FF00 : ($urandom & 32'hFFFF_FFFC);
            s  = 32'(bx * 32 + $urandom_range(0, 16) * 4);
            run(b, s, bx, by, $urandom_range(1, 6), 1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
